// File: rtl/shot_resolver.sv
// shot_resolver: battleship shot resolution.
// Each boat owns five segment slots, each with a 6-bit {row,col} coordinate and an alive bit.
// A shot runs through a four-state FSM: IDLE -> CHECK -> UPDATE -> DONE.
// The per-boat storage and matching live in shot_resolver_boat, one instance per boat.

// Per-boat segment storage, match capture and sunk detection.
module shot_resolver_boat (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       we,
  input  logic [2:0] seg,
  input  logic [5:0] wcoord,
  input  logic       chk,
  input  logic       upd,
  input  logic [5:0] tgt,
  output logic [4:0] alive,
  output logic [4:0] live,
  output logic [4:0] dead,
  output logic       sunk
);
  logic [4:0][5:0] coord;
  logic [4:0]      match;

  // Coordinate compare of every segment slot against the latched target.
  always_comb begin
    match = '0;
    for (int k = 0; k < 5; k++) match[k] = (coord[k] == tgt);
  end

  // Boat sinks on this shot when it still had live segments and the live matches cover all of them.
  assign sunk = (|alive) && ((alive & ~live) == 5'd0);

  // Segment storage, live/dead match capture, and alive-bit clearing.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      coord <= '0;
      alive <= '0;
      live  <= '0;
      dead  <= '0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (we && seg == 3'(k)) begin
          coord[k] <= wcoord;
          alive[k] <= 1'b1;
        end
      end
      if (chk) begin
        live <= match & alive;
        dead <= match & ~alive;
      end
      if (upd) alive <= alive & ~live;
    end
  end
endmodule

// Top level: FSM, placement gating, result registers.
module shot_resolver #(
  parameter int numBarcos = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          place_we,
  input  logic [2:0]                    place_boat,
  input  logic [2:0]                    place_seg,
  input  logic [2:0]                    place_row,
  input  logic [2:0]                    place_col,
  input  logic                          clear,
  input  logic                          shot_valid,
  input  logic [2:0]                    shot_row,
  input  logic [2:0]                    shot_col,
  output logic                          shot_ready,
  output logic                          res_valid,
  output logic                          res_hit,
  output logic                          res_repeat,
  output logic                          res_sunk,
  output logic [2:0]                    res_sunk_id,
  output logic [numBarcos-1:0][4:0]     barcos
);
  typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [5:0]                  tgt_q;
  logic                        accept, pw;
  logic [numBarcos-1:0][4:0]   live, dead;
  logic [numBarcos-1:0]        sunk;
  logic [2:0]                  sunk_id;

  assign shot_ready = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign accept     = shot_ready && shot_valid && !clear;
  // Placement only in IDLE, in range, and never alongside an accepted shot or a clear.
  assign pw = place_we && shot_ready && !shot_valid && !clear &&
              (32'(place_boat) < numBarcos) && (place_seg < 3'd5);

  // Next-state logic; clear forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shot_valid) state_d = CHECK;
      CHECK:   state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch the shot coordinate on acceptance.
  always_ff @(posedge clk) begin
    if (rst)         tgt_q <= '0;
    else if (accept) tgt_q <= {shot_row, shot_col};
  end

  for (genvar b = 0; b < numBarcos; b++) begin : g_boat
    shot_resolver_boat u_boat (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .we     (pw && place_boat == 3'(b)),
      .seg    (place_seg),
      .wcoord ({place_row, place_col}),
      .chk    (state_q == CHECK),
      .upd    (state_q == UPDATE),
      .tgt    (tgt_q),
      .alive  (barcos[b]),
      .live   (live[b]),
      .dead   (dead[b]),
      .sunk   (sunk[b])
    );
  end

  // Lowest-index boat sunk by the current shot.
  always_comb begin
    sunk_id = '0;
    for (int b = numBarcos - 1; b >= 0; b--) if (sunk[b]) sunk_id = 3'(b);
  end

  // Result flags are captured leaving UPDATE and hold until the next shot's DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_hit     <= 1'b0;
      res_repeat  <= 1'b0;
      res_sunk    <= 1'b0;
      res_sunk_id <= '0;
    end else if (state_q == UPDATE && !clear) begin
      res_hit     <= |live;
      res_repeat  <= !(|live) && (|dead);
      res_sunk    <= |sunk;
      res_sunk_id <= sunk_id;
    end
  end
endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver: placement, hit/sink/repeat/miss, throughput, clear and reset abort.
module tb_shot_resolver;
  logic              clk = 1'b0;
  logic              rst, place_we, clear, shot_valid;
  logic [2:0]        place_boat, place_seg, place_row, place_col, shot_row, shot_col;
  logic              shot_ready, res_valid, res_hit, res_repeat, res_sunk;
  logic [2:0]        res_sunk_id;
  logic [4:0][4:0]   barcos;
  int                ncmp = 0, nerr = 0;

  shot_resolver #(.numBarcos(5)) dut (
    .clk(clk), .rst(rst), .place_we(place_we), .place_boat(place_boat), .place_seg(place_seg),
    .place_row(place_row), .place_col(place_col), .clear(clear), .shot_valid(shot_valid),
    .shot_row(shot_row), .shot_col(shot_col), .shot_ready(shot_ready), .res_valid(res_valid),
    .res_hit(res_hit), .res_repeat(res_repeat), .res_sunk(res_sunk), .res_sunk_id(res_sunk_id),
    .barcos(barcos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic place(input int b, input int s, input int r, input int c);
    @(negedge clk);
    place_we = 1'b1; place_boat = 3'(b); place_seg = 3'(s); place_row = 3'(r); place_col = 3'(c);
    @(negedge clk);
    place_we = 1'b0;
  endtask

  // Fire one shot from IDLE and check latency, flags and board at the DONE cycle.
  task automatic shoot(input string tag, input int r, input int c, input logic hit, input logic rep,
                       input logic snk, input int id, input logic [24:0] exp_b);
    int lat;
    @(negedge clk);
    chk({tag, ".ready"}, shot_ready, 1);
    shot_valid = 1'b1; shot_row = 3'(r); shot_col = 3'(c);
    @(negedge clk);
    shot_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, 3);
    chk({tag, ".hit"}, res_hit, hit);
    chk({tag, ".rep"}, res_repeat, rep);
    chk({tag, ".sunk"}, res_sunk, snk);
    if (snk) chk({tag, ".id"}, res_sunk_id, id);
    chk({tag, ".barcos"}, barcos, exp_b);
    @(negedge clk);
    chk({tag, ".vld_off"}, res_valid, 0);
    chk({tag, ".idle"}, shot_ready, 1);
  endtask

  initial begin
    int nrdy, nres;
    rst = 1'b1; place_we = 1'b0; clear = 1'b0; shot_valid = 1'b0;
    place_boat = '0; place_seg = '0; place_row = '0; place_col = '0; shot_row = '0; shot_col = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", shot_ready, 1);
    chk("rst.valid", res_valid, 0);
    chk("rst.barcos", barcos, 0);
    chk("rst.flags", {res_hit, res_repeat, res_sunk, res_sunk_id}, 0);
    rst = 1'b0;

    // Boat 0: two segments, hit then sink then repeat.
    place(0, 0, 2, 3);
    place(0, 1, 2, 4);
    chk("place.b0", barcos, 25'h3);
    shoot("s23", 2, 3, 1, 0, 0, 0, 25'h2);
    shoot("s24", 2, 4, 1, 0, 1, 0, 25'h0);
    shoot("s23r", 2, 3, 0, 1, 0, 0, 25'h0);

    // Boats 1 and 3 share (5,5); boat 2 elsewhere.
    place(1, 0, 5, 5);
    place(3, 0, 5, 5);
    place(2, 0, 1, 1);
    chk("place.b123", barcos, 25'h8420);
    shoot("s55", 5, 5, 1, 0, 1, 1, 25'h400);
    shoot("miss", 7, 7, 0, 0, 0, 0, 25'h400);
    shoot("s00", 0, 0, 0, 1, 0, 0, 25'h400);

    // Out-of-range placements are dropped.
    place(5, 0, 3, 3);
    place(0, 5, 3, 3);
    chk("place.oor", barcos, 25'h400);

    // Placement coinciding with a shot, and held through it, is dropped.
    @(negedge clk);
    shot_valid = 1'b1; shot_row = 3'd6; shot_col = 3'd6;
    place_we = 1'b1; place_boat = 3'd4; place_seg = 3'd0; place_row = 3'd3; place_col = 3'd3;
    @(negedge clk);
    shot_valid = 1'b0;
    chk("pw.busy", shot_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pw.done", res_valid, 1);
    place_we = 1'b0;
    chk("pw.dropped", barcos, 25'h400);

    // Back-to-back shots with shot_valid held: one accept per four cycles.
    @(negedge clk);
    shot_valid = 1'b1; shot_row = 3'd6; shot_col = 3'd6;
    nrdy = 0; nres = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (shot_ready) nrdy++;
      if (res_valid) nres++;
      if (i == 16) shot_valid = 1'b0;
    end
    chk("tput.ready", nrdy, 4);
    chk("tput.results", nres, 4);
    @(negedge clk);
    chk("tput.idle", shot_ready, 1);

    // Reset during UPDATE aborts the shot.
    place(0, 0, 4, 4);
    @(negedge clk);
    shot_valid = 1'b1; shot_row = 3'd4; shot_col = 3'd4;
    @(negedge clk);
    shot_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstupd.valid", res_valid, 0);
    chk("rstupd.barcos", barcos, 0);
    chk("rstupd.ready", shot_ready, 1);
    @(negedge clk);
    chk("rstupd.valid2", res_valid, 0);

    // Clear mid-shot, clear over placement, clear over shot.
    place(0, 0, 1, 2);
    @(negedge clk);
    shot_valid = 1'b1; shot_row = 3'd1; shot_col = 3'd2;
    @(negedge clk);
    shot_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    chk("clr.ready", shot_ready, 1);
    chk("clr.barcos", barcos, 0);
    place_we = 1'b1; place_boat = 3'd2; place_seg = 3'd1; place_row = 3'd1; place_col = 3'd1;
    shot_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0; place_we = 1'b0; shot_valid = 1'b0;
    chk("clr.over", {shot_ready, res_valid, barcos}, {2'b10, 25'h0});
    shoot("empty", 1, 2, 0, 0, 0, 0, 25'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
